// File: rtl/ps2_rx_deserializer.sv
// ps2_rx_deserializer: filtered PS/2 device-to-host frame receiver with host inhibit.
// Optional stalled-frame timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_deserializer #(
  parameter int clkf = 50000000,
  parameter int filter_len = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  input  logic       inhibit,
  output logic       ps2_clk_oe,
  output logic [7:0] rx,
  output logic       rx_valid,
  output logic       error
);
  localparam int FW = $clog2(filter_len + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [1:0] clk_sy, dat_sy;
  logic filt, filt_d, par, ev;
  logic [FW-1:0] fcnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
`ifdef PS2_RX_TIMEOUT_EN
  localparam int tmo_max = clkf / 500;
  localparam int TW = $clog2(tmo_max + 1);
  logic [TW-1:0] tmo;
`endif
  assign ev = filt_d & ~filt & ~inhibit;
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sy <= 2'b11;
      dat_sy <= 2'b11;
      filt <= 1'b1;
      filt_d <= 1'b1;
      fcnt <= '0;
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      rx <= '0;
      rx_valid <= 1'b0;
      error <= 1'b0;
      ps2_clk_oe <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo <= '0;
`endif
    end else begin
      clk_sy <= {clk_sy[0], ps2_clk_in};
      dat_sy <= {dat_sy[0], ps2_dat_in};
      filt_d <= filt;
      // level only flips after filter_len consecutive disagreeing samples
      if (clk_sy[1] == filt) fcnt <= '0;
      else if (fcnt == FW'(filter_len - 1)) begin
        filt <= clk_sy[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
      ps2_clk_oe <= inhibit;
      rx_valid <= 1'b0;
      error <= 1'b0;
      if (inhibit) begin
        state <= IDLE;
        bit_cnt <= '0;
      end else if (ev) begin
        case (state)
          IDLE: if (!dat_sy[1]) begin
            state <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg <= {dat_sy[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= dat_sy[1];
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            rx <= shreg;
            rx_valid <= 1'b1;
            error <= ~(^{shreg, par}) | ~dat_sy[1];
          end
          default: state <= IDLE;
        endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      tmo <= (ev || inhibit || state == IDLE) ? '0 : tmo + 1'b1;
      if (!inhibit && !ev && state != IDLE && tmo == TW'(tmo_max - 1)) begin
        state <= IDLE;
        rx_valid <= 1'b1;
        error <= 1'b1;
        rx <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// tb_ps2_rx_deserializer: directed PS/2 frames with a queue scoreboard checked by a monitor.
module tb_ps2_rx_deserializer;
  localparam int HALF = 20;
  logic clk = 1'b0, reset = 1'b1, ps2_clk_in = 1'b1, ps2_dat_in = 1'b1, inhibit = 1'b0;
  logic ps2_clk_oe, rx_valid, error;
  logic [7:0] rx;
  int compared = 0, mismatched = 0, pulses = 0;
  logic [8:0] q[$];

  ps2_rx_deserializer #(.clkf(50000), .filter_len(8)) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .inhibit(inhibit), .ps2_clk_oe(ps2_clk_oe), .rx(rx), .rx_valid(rx_valid), .error(error));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        logic [8:0] exp;
        pulses++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse got rx=%h err=%b, none expected", rx, error);
        end else begin
          exp = q.pop_front();
          compared++;
          if ({rx, error} !== exp) begin
            mismatched++;
            $display("FAIL frame got rx=%h err=%b expected rx=%h err=%b", rx, error, exp[8:1], exp[0]);
          end
        end
      end else if (error) begin
        mismatched++;
        $display("FAIL error_without_valid got error=1 expected 0");
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_dat_in = b[i];
      repeat (HALF) @(negedge clk);
      ps2_clk_in = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk_in = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input logic s, input logic expect_it);
    if (expect_it) q.push_back({d, ~(^{d, p}) | ~s});
    send_bits({s, p, d, 1'b0}, 11);
    repeat (HALF) @(negedge clk);
    ps2_dat_in = 1'b1;
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    check("reset_rx", rx, 8'h00);
    check("reset_valid", {7'd0, rx_valid}, 8'h00);
    check("reset_error", {7'd0, error}, 8'h00);
    check("reset_oe", {7'd0, ps2_clk_oe}, 8'h00);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    frame(8'h1C, 1'b0, 1'b1, 1'b1);
    frame(8'h1C, 1'b1, 1'b1, 1'b1);
    frame(8'h1C, 1'b0, 1'b0, 1'b1);
    // short low glitch with data low must not start a frame
    ps2_dat_in = 1'b0;
    ps2_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk_in = 1'b1;
    repeat (30) @(negedge clk);
    ps2_dat_in = 1'b1;
    repeat (10) @(negedge clk);
    frame(8'hF0, 1'b1, 1'b1, 1'b1);
    // inhibit after start + 4 data bits
    send_bits({2'b11, 8'h5A, 1'b0}, 5);
    @(negedge clk) inhibit = 1'b1;
    @(negedge clk);
    check("oe_on_inhibit", {7'd0, ps2_clk_oe}, 8'h01);
    repeat (5) @(negedge clk);
    inhibit = 1'b0;
    @(negedge clk);
    check("oe_after_release", {7'd0, ps2_clk_oe}, 8'h00);
    repeat (10) @(negedge clk);
    frame(8'h5A, 1'b1, 1'b1, 1'b1);
    // stalled frame
`ifdef PS2_RX_TIMEOUT_EN
    q.push_back({8'h00, 1'b1});
`endif
    snap = pulses;
    send_bits({2'b11, 8'hA5, 1'b0}, 5);
    repeat (300) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    check("stall_pulses", 8'(pulses - snap), 8'd1);
`else
    check("stall_pulses", 8'(pulses - snap), 8'd0);
`endif
    @(negedge clk) inhibit = 1'b1;
    repeat (3) @(negedge clk);
    inhibit = 1'b0;
    repeat (10) @(negedge clk);
    // reset while waiting for the parity bit
    send_bits({2'b11, 8'h77, 1'b0}, 9);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rx", rx, 8'h00);
    check("rst_valid", {7'd0, rx_valid}, 8'h00);
    check("rst_error", {7'd0, error}, 8'h00);
    check("rst_oe", {7'd0, ps2_clk_oe}, 8'h00);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    frame(8'h29, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 8'(q.size()), 8'd0);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
